// File: rtl/autotest_pkg.sv
// autotest_pkg: shared types and constants for the autotest sequencer.
//   state_e      - sequencer states
//   STAT_OK      - status byte for a vector that finished normally
//   STAT_TIMEOUT - status byte for a vector aborted by the run timeout
package autotest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RST,
    RUN,
    EMIT,
    NEXT,
    DONE
  } state_e;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'hFF;

endpackage

// File: rtl/autotest_seq_if.sv
// autotest_seq_if: byte stream with valid/ready handshake.
//   valid - producer has a byte on data
//   ready - consumer accepts data this cycle when valid is also high
//   data  - byte payload
// master = producer side, slave = consumer side.
interface autotest_seq_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: parallel-load, MSB-first byte emitter.
//   clk, rst    - clock, synchronous active-high reset
//   load        - capture load_data and start emitting N_BYTES bytes
//   load_data   - record to emit, first byte in the top bits
//   out_if      - byte stream (master)
//   last_xfer   - final byte of the record is being accepted this cycle
module byte_serializer #(
  parameter int N_BYTES = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [N_BYTES*8-1:0]   load_data,
  autotest_seq_if.master         out_if,
  output logic                   last_xfer
);

  localparam int CW = $clog2(N_BYTES + 1);

  logic [N_BYTES*8-1:0] sh_q, sh_d;
  logic [CW-1:0]        left_q, left_d;
  logic                 xfer;

  assign out_if.valid = (left_q != '0);
  assign out_if.data  = sh_q[N_BYTES*8-1 -: 8];
  assign xfer         = out_if.valid & out_if.ready;
  assign last_xfer    = xfer && (left_q == CW'(1));

  always_comb begin
    sh_d   = sh_q;
    left_d = left_q;
    if (load) begin
      sh_d   = load_data;
      left_d = CW'(N_BYTES);
    end else if (xfer) begin
      // zero fill keeps out_data at 0 once the record has drained
      sh_d   = sh_q << 8;
      left_d = left_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      left_q <= '0;
    end else begin
      sh_q   <= sh_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/autotest_seq.sv
// autotest_seq: reads key/IV test vectors from a byte stream, runs a keyed
// UUT through reset and run, times the run and emits one result record per
// vector on the output byte stream.
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin a batch of num_vectors vectors (ignored while busy)
//   in_if           - vector byte stream (slave), key bytes then IV bytes
//   out_if          - result byte stream (master)
//   rst_uut, key_uut, iv_uut, end_uut, block_o_uut - UUT control/result
//   busy, done, timeout_seen - batch status
// Build option: AUTOTEST_CYCLE_COUNT_EN adds the CNT_W/8 run-length bytes
// between result and status in each record.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | shifting in key then IV bytes, UUT held in reset
// RST   | UUT reset for RST_CYCLES cycles, run counter cleared
// RUN   | UUT released, counting cycles until end_uut or timeout
// EMIT  | record draining through the serializer, UUT parked in reset
// NEXT  | one vector finished, decide on another LOAD or DONE
// DONE  | batch over, done pulse follows
module autotest_seq
  import autotest_pkg::*;
#(
  parameter int KEY_W          = 80,
  parameter int IV_W           = 80,
  parameter int RES_W          = 64,
  parameter int CNT_W          = 32,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_vectors,
  autotest_seq_if.slave     in_if,
  autotest_seq_if.master    out_if,
  output logic              rst_uut,
  output logic [KEY_W-1:0]  key_uut,
  output logic [IV_W-1:0]   iv_uut,
  input  logic              end_uut,
  input  logic [RES_W-1:0]  block_o_uut,
  output logic              busy,
  output logic              done,
  output logic              timeout_seen
);

  localparam int LD_W     = KEY_W + IV_W;
  localparam int LD_BYTES = LD_W / 8;
  localparam int LCW      = $clog2(LD_BYTES + 1);
  localparam int RCW      = $clog2(RST_CYCLES + 1);
`ifdef AUTOTEST_CYCLE_COUNT_EN
  localparam int REC_BYTES = RES_W/8 + CNT_W/8 + 1;
`else
  localparam int REC_BYTES = RES_W/8 + 1;
`endif

  state_e               state_q, state_d;
  logic [15:0]          vec_left_q, vec_left_d;
  logic [LCW-1:0]       ld_left_q, ld_left_d;
  logic [LD_W-1:0]      ld_sr_q, ld_sr_d;
  logic [RCW-1:0]       rst_tmr_q, rst_tmr_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [CNT_W-1:0]     cyc_inc;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 accept;
  logic                 ser_load;
  logic                 ser_last;
  logic [REC_BYTES*8-1:0] ser_data;

  assign in_if.ready  = (state_q == LOAD);
  assign accept       = in_if.valid & in_if.ready;
  assign rst_uut      = (state_q != RUN);
  assign key_uut      = ld_sr_q[LD_W-1 -: KEY_W];
  assign iv_uut       = ld_sr_q[IV_W-1:0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_seen = tmo_q;
  assign cyc_inc      = cyc_q + CNT_W'(1);

  // In RUN, end_uut selects the normal record; otherwise this is only
  // loaded on the cycle the counter reaches the timeout.
`ifdef AUTOTEST_CYCLE_COUNT_EN
  assign ser_data = {block_o_uut, (end_uut ? cyc_q : cyc_inc),
                     (end_uut ? STAT_OK : STAT_TIMEOUT)};
`else
  assign ser_data = {block_o_uut, (end_uut ? STAT_OK : STAT_TIMEOUT)};
`endif

  always_comb begin
    state_d    = state_q;
    vec_left_d = vec_left_q;
    ld_left_d  = ld_left_q;
    ld_sr_d    = ld_sr_q;
    rst_tmr_d  = rst_tmr_q;
    cyc_d      = cyc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmo_d      = tmo_q;
    ser_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_left_d = num_vectors;
          ld_left_d  = LCW'(LD_BYTES - 1);
          tmo_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = (num_vectors == 16'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          ld_sr_d = {ld_sr_q[LD_W-9:0], in_if.data};
          if (ld_left_q == '0) begin
            rst_tmr_d = RCW'(RST_CYCLES - 1);
            state_d   = RST;
          end else begin
            ld_left_d = ld_left_q - LCW'(1);
          end
        end
      end
      RST: begin
        cyc_d = '0;
        if (rst_tmr_q == '0) begin
          state_d = RUN;
        end else begin
          rst_tmr_d = rst_tmr_q - RCW'(1);
        end
      end
      RUN: begin
        if (end_uut) begin
          ser_load = 1'b1;
          state_d  = EMIT;
        end else if (cyc_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          ser_load = 1'b1;
          tmo_d    = 1'b1;
          state_d  = EMIT;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      EMIT: begin
        if (ser_last) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        vec_left_d = vec_left_q - 16'd1;
        ld_left_d  = LCW'(LD_BYTES - 1);
        state_d    = (vec_left_q == 16'd1) ? DONE : LOAD;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_left_q <= '0;
      ld_left_q  <= '0;
      ld_sr_q    <= '0;
      rst_tmr_q  <= '0;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_left_q <= vec_left_d;
      ld_left_q  <= ld_left_d;
      ld_sr_q    <= ld_sr_d;
      rst_tmr_q  <= rst_tmr_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  byte_serializer #(
    .N_BYTES (REC_BYTES)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (ser_data),
    .out_if    (out_if),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_autotest_seq.sv
module tb_autotest_seq;

  localparam int TO   = 120;
  localparam int RSTC = 4;
`ifdef AUTOTEST_CYCLE_COUNT_EN
  localparam int REC = 13;
`else
  localparam int REC = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic        rst_uut;
  logic [79:0] key_uut;
  logic [79:0] iv_uut;
  logic        end_uut;
  logic [63:0] block_o_uut;
  logic        busy;
  logic        done;
  logic        timeout_seen;

  autotest_seq_if in_if ();
  autotest_seq_if out_if ();

  autotest_seq #(
    .KEY_W          (80),
    .IV_W           (80),
    .RES_W          (64),
    .CNT_W          (32),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vectors  (num_vectors),
    .in_if        (in_if),
    .out_if       (out_if),
    .rst_uut      (rst_uut),
    .key_uut      (key_uut),
    .iv_uut       (iv_uut),
    .end_uut      (end_uut),
    .block_o_uut  (block_o_uut),
    .busy         (busy),
    .done         (done),
    .timeout_seen (timeout_seen)
  );

  always #5 clk = ~clk;

  // UUT model: finishes after lat_g released cycles; result mixes key and IV
  int          k;
  int          lat_g;
  logic [63:0] res_xor;
  always @(posedge clk) begin
    if (rst_uut) k <= 0;
    else         k <= k + 1;
  end
  assign end_uut     = !rst_uut && (k >= lat_g);
  assign block_o_uut = key_uut[63:0] ^ iv_uut[79:16] ^ res_xor;

  int errs = 0;
  int checks = 0;

  logic [79:0] vk   [4];
  logic [79:0] viv  [4];
  logic [63:0] vrx  [4];
  int          vlat [4];
  logic [7:0]  exp_b [13];
  logic [7:0]  got_b [13];

  typedef struct {
    int          lat;
    logic [7:0]  stat;
    logic [31:0] cnt;
  } tv_t;
  tv_t tbl [6];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic make_exp(input logic [79:0] kk, input logic [79:0] ii,
                          input logic [63:0] rx, input int lt);
    logic [63:0] res;
    logic [31:0] cnt;
    res = kk[63:0] ^ ii[79:16] ^ rx;
    cnt = (lt >= TO) ? 32'(TO) : 32'(lt);
    for (int i = 0; i < 8; i++) exp_b[i] = res[63-8*i -: 8];
`ifdef AUTOTEST_CYCLE_COUNT_EN
    for (int i = 0; i < 4; i++) exp_b[8+i] = cnt[31-8*i -: 8];
`endif
    exp_b[REC-1] = (lt >= TO) ? 8'hFF : 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    bit sent;
    n = 0;
    sent = 0;
    while (!sent && n < 100) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_if.valid = 1'b0;
      end else begin
        in_if.valid = 1'b1;
        in_if.data  = b;
        if (in_if.ready) sent = 1;
      end
      @(negedge clk);
      n++;
    end
    in_if.valid = 1'b0;
    if (!sent) fail("in_accept");
  endtask

  task automatic send_vector(input logic [79:0] kk, input logic [79:0] ii, input bit gaps);
    logic [159:0] kv;
    kv = {kk, ii};
    for (int i = 0; i < 20; i++) send_byte(kv[159-8*i -: 8], gaps);
  endtask

  task automatic recv_record(input bit rr);
    int cnt;
    int cyc;
    bit stall;
    logic [7:0] held;
    cnt = 0;
    cyc = 0;
    stall = 0;
    held = 8'h00;
    while (cnt < REC && cyc < 400) begin
      if (stall) check("out_hold", out_if.data, held);
      out_if.ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_if.valid && out_if.ready) begin
        got_b[cnt] = out_if.data;
        cnt++;
        stall = 0;
      end else begin
        stall = out_if.valid;
        held  = out_if.data;
      end
      @(negedge clk);
      cyc++;
    end
    out_if.ready = 1'b0;
    if (cnt < REC) fail("out_record");
    if (!rr) check("out_rate", cyc, REC);
    check("out_idle_after_rec", out_if.valid, 1'b0);
    for (int i = 0; i < REC; i++) check($sformatf("rec_byte%0d", i), got_b[i], exp_b[i]);
  endtask

  task automatic run_vector(input int idx, input bit gaps, input bit rr, input bit poke);
    int n;
    int m;
    lat_g   = vlat[idx];
    res_xor = vrx[idx];
    make_exp(vk[idx], viv[idx], vrx[idx], vlat[idx]);
    send_vector(vk[idx], viv[idx], gaps);
    check("key_uut", key_uut, vk[idx]);
    check("iv_uut", iv_uut, viv[idx]);
    n = 0;
    if (poke) begin
      start = 1'b1;
      num_vectors = 16'd7;
    end
    while (rst_uut && n < 20) begin
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_uut_len", n, RSTC);
    m = 0;
    while (!out_if.valid && m < TO + 20) begin
      m++;
      @(negedge clk);
    end
    check("run_len", m, (vlat[idx] < TO) ? vlat[idx] + 1 : TO);
    check("rst_uut_in_emit", rst_uut, 1'b1);
    recv_record(rr);
  endtask

  task automatic batch(input int nv, input bit gaps, input bit rr, input bit poke);
    bit exp_tmo;
    exp_tmo = 0;
    start = 1'b1;
    num_vectors = 16'(nv);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("tmo_cleared", timeout_seen, 1'b0);
    check("in_ready_after_start", in_if.ready, (nv != 0));
    for (int i = 0; i < nv; i++) begin
      run_vector(i, gaps, rr, poke && (i == 0));
      if (vlat[i] >= TO) exp_tmo = 1;
      if (i < nv - 1) begin
        @(negedge clk);
        check("next_in_ready", in_if.ready, 1'b1);
      end
    end
    if (nv > 0) @(negedge clk);
    check("done_early", done, 1'b0);
    check("busy_in_done", busy, 1'b1);
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("out_valid_end", out_if.valid, 1'b0);
    check("timeout_seen", timeout_seen, exp_tmo);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [103:0] lit;
    int n;
    rst = 1'b1;
    start = 1'b0;
    num_vectors = 16'd0;
    in_if.valid = 1'b0;
    in_if.data = 8'h00;
    out_if.ready = 1'b0;
    lat_g = 1000;
    res_xor = '0;

    tbl[0] = '{lat: 0,   stat: 8'h00, cnt: 32'd0};
    tbl[1] = '{lat: 1,   stat: 8'h00, cnt: 32'd1};
    tbl[2] = '{lat: 7,   stat: 8'h00, cnt: 32'd7};
    tbl[3] = '{lat: 119, stat: 8'h00, cnt: 32'd119};
    tbl[4] = '{lat: 120, stat: 8'hFF, cnt: 32'd120};
    tbl[5] = '{lat: 300, stat: 8'hFF, cnt: 32'd120};

    repeat (3) @(negedge clk);
    check("rst_rst_uut", rst_uut, 1'b1);
    check("rst_key", key_uut, 80'h0);
    check("rst_iv", iv_uut, 80'h0);
    check("rst_in_ready", in_if.ready, 1'b0);
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_out_data", out_if.data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tmo", timeout_seen, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // empty batch
    batch(0, 0, 0, 0);

    // reference vector, with a start pulse while busy that must be ignored
    vk[0]   = 80'h0123_4567_89AB_CDEF_0123;
    viv[0]  = 80'hFEDC_BA98_7654_3210_FEDC;
    vrx[0]  = 64'hDEADBEEFCAFEF00D ^ vk[0][63:0] ^ viv[0][79:16];
    vlat[0] = 100;
    batch(1, 0, 0, 1);
`ifdef AUTOTEST_CYCLE_COUNT_EN
    lit = 104'hDEADBEEFCAFEF00D_00000064_00;
`else
    lit = {32'h0, 72'hDEADBEEFCAFEF00D_00};
`endif
    for (int i = 0; i < REC; i++) check($sformatf("ref_byte%0d", i), got_b[i], lit[8*(REC-1-i) +: 8]);

    // reset in RUN
    lat_g = 50;
    res_xor = '0;
    start = 1'b1;
    num_vectors = 16'd2;
    @(negedge clk);
    start = 1'b0;
    send_vector({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom(), 16'($urandom())}, 1);
    n = 0;
    while (rst_uut && n < 20) begin n++; @(negedge clk); end
    repeat (5) @(negedge clk);
    check("in_run_before_rst", rst_uut, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("run_rst_rst_uut", rst_uut, 1'b1);
    check("run_rst_out_valid", out_if.valid, 1'b0);
    check("run_rst_busy", busy, 1'b0);
    check("run_rst_in_ready", in_if.ready, 1'b0);
    check("run_rst_key", key_uut, 80'h0);
    rst = 1'b0;
    @(negedge clk);

    // reset in EMIT with the output stalled
    lat_g = 3;
    start = 1'b1;
    num_vectors = 16'd1;
    @(negedge clk);
    start = 1'b0;
    send_vector({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom(), 16'($urandom())}, 0);
    n = 0;
    while (!out_if.valid && n < 50) begin n++; @(negedge clk); end
    check("emit_reached", out_if.valid, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("emit_rst_out_valid", out_if.valid, 1'b0);
    check("emit_rst_out_data", out_if.data, 8'h00);
    check("emit_rst_busy", busy, 1'b0);
    check("emit_rst_rst_uut", rst_uut, 1'b1);
    check("emit_rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // latency table, one vector per batch
    for (int t = 0; t < 6; t++) begin
      vk[0]   = {$urandom(), $urandom(), 16'($urandom())};
      viv[0]  = {$urandom(), $urandom(), 16'($urandom())};
      vrx[0]  = {$urandom(), $urandom()};
      vlat[0] = tbl[t].lat;
      batch(1, 0, 0, 0);
      check($sformatf("tbl%0d_status", t), got_b[REC-1], tbl[t].stat);
`ifdef AUTOTEST_CYCLE_COUNT_EN
      check($sformatf("tbl%0d_count", t), {got_b[8], got_b[9], got_b[10], got_b[11]}, tbl[t].cnt);
`endif
    end

    // randomized multi-vector batches with stalls on both streams
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) begin
        vk[i]   = {$urandom(), $urandom(), 16'($urandom())};
        viv[i]  = {$urandom(), $urandom(), 16'($urandom())};
        vrx[i]  = {$urandom(), $urandom()};
        vlat[i] = $urandom_range(0, 140);
      end
      batch(3, 1, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/autotest_seq.md
# autotest_seq

Parametrised successor of the SD-card autotest sequencer. Consumes a byte stream of test vectors (key then IV) read from the SD card, drives a generic keyed UUT through reset/run, and measures run length in clock cycles with a timeout. Emits a byte-stream result record per vector for the SD write path. Sits between the SD SPI host's byte-level read/write logic and the UUT; the SD command sequencing lives outside this block.

## Interface
- KEY_W, 80, UUT key width in bits (multiple of 8)
- IV_W, 80, UUT IV width in bits (multiple of 8)
- RES_W, 64, UUT result width in bits (multiple of 8)
- CNT_W, 32, cycle-counter width (multiple of 8)
- RST_CYCLES, 4, cycles `rst_uut` is held high per vector (≥1)
- TIMEOUT_CYCLES, 2**20, maximum RUN cycles before abort (< 2**CNT_W)
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begin a batch (ignored while `busy`)
- num_vectors  in  16  vectors in batch, sampled on `start`
- in_valid / in_ready / in_data  in/out/in  1/1/8  vector byte stream
- out_valid / out_ready / out_data  out/in/out  1/1/8  result byte stream
- rst_uut  out  1  UUT reset, active-high
- key_uut  out  KEY_W  UUT key
- iv_uut  out  IV_W  UUT IV
- end_uut  in  1  UUT finished (level)
- block_o_uut  in  RES_W  UUT result, valid when `end_uut`=1
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end
- timeout_seen  out  1  sticky; any vector timed out this batch

## Operation
- Reset values: rst_uut=1, key_uut=0, iv_uut=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, timeout_seen=0, state IDLE.
- IDLE: on `start` latch `num_vectors`, clear `timeout_seen`, busy=1; if num_vectors=0 go DONE, else LOAD.
- LOAD: in_ready=1; each accepted byte (in_valid&in_ready) shifts in MSB-first: first KEY_W/8 bytes fill key_uut (first byte → bits [KEY_W-1:KEY_W-8]), next IV_W/8 bytes fill iv_uut. After last byte → RST.
- RST: rst_uut=1 for RST_CYCLES cycles, cycle counter cleared → RUN.
- RUN: rst_uut=0; counter +1 each cycle end_uut=0. end_uut=1 → capture block_o_uut and counter, status 0x00 → EMIT. Counter reaching TIMEOUT_CYCLES → capture block_o_uut as-is, status 0xFF, set timeout_seen → EMIT.
- EMIT: rst_uut=1 (UUT parked). Record MSB-first: RES_W/8 result bytes, then CNT_W/8 count bytes (if macro enabled), then 1 status byte. out_data stable while out_valid=1 and out_ready=0.
- NEXT: decrement remaining; zero → DONE else LOAD.
- DONE: done=1 one cycle, busy=0 → IDLE.
- `rst` mid-operation: next cycle all outputs at reset values; partial record abandoned.
- `start` while busy: ignored. end_uut high on first RUN cycle → count 0.

## Timing
- start → first in_ready: 1 cycle (0 if num_vectors=0: done 2 cycles after start).
- Last LOAD byte → rst_uut high exactly RST_CYCLES cycles, then low.
- Count = RUN cycles with end_uut=0 before end_uut sampled high.
- end_uut/timeout → out_valid next cycle; one byte per cycle under continuous out_ready.
- Last status byte accepted → LOAD in_ready 2 cycles later (NEXT 1 cycle).

## Configuration
- AUTOTEST_CYCLE_COUNT_EN defined: count bytes included, record = RES_W/8 + CNT_W/8 + 1 bytes.
- Undefined: no count bytes, record = RES_W/8 + 1; counter still runs for timeout.

## Structure
- Package `autotest_pkg`: state enum (IDLE, LOAD, RST, RUN, EMIT, NEXT, DONE), status constants STAT_OK=8'h00, STAT_TIMEOUT=8'hFF.
- Sub-module `byte_serializer`: parallel-load, MSB-first valid/ready byte output, length as parameter.

## Test plan
- KEY=80'h0123…, IV=80'hFEDC…, num_vectors=1, UUT model asserts end after 100 cycles with result 64'hDEADBEEFCAFEF00D → record DE AD BE EF CA FE F0 0D 00 00 00 64 00, done pulse.
- TIMEOUT_CYCLES=16, end_uut never rises → count 00 00 00 10, status FF, timeout_seen=1.
- num_vectors=3, in_valid toggled randomly, out_ready 50% → 3 complete records, byte order intact, no drops.
- num_vectors=0 → done 2 cycles after start, no in_ready, no out_valid.
- rst asserted during RUN and during EMIT → next cycle rst_uut=1, out_valid=0, busy=0; new start runs cleanly.
- Macro undefined, same as scenario 1 → record DE AD BE EF CA FE F0 0D 00 (9 bytes).
